// File: rtl/spi_chain_arbiter_if.sv
// Client and SPI pin bundle for spi_chain_arbiter.
// The master modport is the arbiter's view; the slave modport is the view from the clients and the SPI slaves.
interface spi_chain_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8
);
   logic [N_REQ-1:0]        req;
   logic [N_REQ*DATA_W-1:0] tx_data;
   logic [N_REQ-1:0]        gnt;
   logic [N_REQ-1:0]        done;
   logic [DATA_W-1:0]       rx_data;
   logic                    busy;
   logic                    sclk;
   logic                    mosi;
   logic                    cs;
   logic                    miso;

   modport master (
      input  req, tx_data, miso,
      output gnt, done, rx_data, busy, sclk, mosi, cs
   );

   modport slave (
      output req, tx_data, miso,
      input  gnt, done, rx_data, busy, sclk, mosi, cs
   );
endinterface

// File: rtl/spi_chain_arbiter.sv
// Round-robin arbiter that shares one mode-0 SPI master link between N_REQ requesters.
// It sequences each frame and contains its own sclk divider and shift registers.
//
// state   | meaning
// S_IDLE  | cs high, sample req, grant the round-robin winner
// S_SETUP | cs low, sclk low, CS_SETUP cycles before the first edge
// S_SHIFT | sclk toggles every CLK_DIV cycles, DATA_W bits MSB-first
// S_HOLD  | sclk low, mosi held, CS_HOLD cycles before cs release
// S_GAP   | cs high, still busy, CS_GAP cycles before the next grant
module spi_chain_arbiter #(
   parameter int N_REQ    = 4,
   parameter int DATA_W   = 8,
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int CS_GAP   = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   spi_chain_arbiter_if.master  bus
);
   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = 16;
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(CS_GAP - 1);
   localparam logic [CNT_W-1:0] DIV_LD   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] EDGE_LD  = CNT_W'(2 * DATA_W - 1);
   localparam logic [PTR_W:0]   NREQ_W   = (PTR_W + 1)'(N_REQ);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  edge_q, edge_d;
   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]  win_q, win_d;
   logic [N_REQ-1:0]  gnt_q, gnt_d;
   logic [N_REQ-1:0]  done_q, done_d;
   logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
   logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              busy_q, busy_d;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;
   logic              cs_q, cs_d;

   logic              found;
   logic [PTR_W-1:0]  pick;
   logic [PTR_W:0]    idx;
   logic [DATA_W-1:0] pick_data;

   // First requester at or after rr_ptr, wrapping modulo N_REQ.
   always_comb begin
      found = 1'b0;
      pick  = rr_ptr_q;
      idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = {1'b0, rr_ptr_q} + (PTR_W + 1)'(k);
         if (idx >= NREQ_W) idx = idx - NREQ_W;
         if (!found && bus.req[idx[PTR_W-1:0]]) begin
            found = 1'b1;
            pick  = idx[PTR_W-1:0];
         end
      end
      pick_data = bus.tx_data[int'(pick) * DATA_W +: DATA_W];
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      edge_d    = edge_q;
      rr_ptr_d  = rr_ptr_q;
      win_d     = win_q;
      gnt_d     = gnt_q;
      done_d    = '0;
      tx_sr_d   = tx_sr_q;
      rx_sr_d   = rx_sr_q;
      rx_data_d = rx_data_q;
      busy_d    = busy_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      cs_d      = cs_q;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               state_d = S_SETUP;
               cnt_d   = SETUP_LD;
               win_d   = pick;
               gnt_d   = N_REQ'(1) << pick;
               busy_d  = 1'b1;
               cs_d    = 1'b0;
               tx_sr_d = pick_data;
               mosi_d  = pick_data[DATA_W-1];
            end
         end
         S_SETUP: begin
            if (cnt_q == '0) begin
               state_d = S_SHIFT;
               cnt_d   = DIV_LD;
               edge_d  = EDGE_LD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_SHIFT: begin
            if (cnt_q == '0) begin
               cnt_d  = DIV_LD;
               sclk_d = ~sclk_q;
               if (!sclk_q) begin
                  rx_sr_d = {rx_sr_q[DATA_W-2:0], bus.miso};
               end else if (edge_q != '0) begin
                  // The final fall leaves the last bit on mosi through HOLD.
                  tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
                  mosi_d  = tx_sr_q[DATA_W-2];
               end
               if (edge_q == '0) begin
                  state_d = S_HOLD;
                  cnt_d   = HOLD_LD;
               end else begin
                  edge_d = edge_q - 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_HOLD: begin
            if (cnt_q == '0) begin
               state_d   = S_GAP;
               cnt_d     = GAP_LD;
               cs_d      = 1'b1;
               mosi_d    = 1'b0;
               gnt_d     = '0;
               done_d    = gnt_q;
               rx_data_d = rx_sr_q;
               rr_ptr_d  = (win_q == LAST_IDX) ? '0 : win_q + 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         edge_q    <= '0;
         rr_ptr_q  <= '0;
         win_q     <= '0;
         gnt_q     <= '0;
         done_q    <= '0;
         tx_sr_q   <= '0;
         rx_sr_q   <= '0;
         rx_data_q <= '0;
         busy_q    <= 1'b0;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
         cs_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         edge_q    <= edge_d;
         rr_ptr_q  <= rr_ptr_d;
         win_q     <= win_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         tx_sr_q   <= tx_sr_d;
         rx_sr_q   <= rx_sr_d;
         rx_data_q <= rx_data_d;
         busy_q    <= busy_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         cs_q      <= cs_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.done    = done_q;
   assign bus.rx_data = rx_data_q;
   assign bus.busy    = busy_q;
   assign bus.sclk    = sclk_q;
   assign bus.mosi    = mosi_q;
   assign bus.cs      = cs_q;
endmodule

// File: tb/tb_spi_chain_arbiter.sv
// Directed bench for spi_chain_arbiter: arbitration order, frame timing, shifting and reset abort.
module tb_spi_chain_arbiter;
   localparam int N_REQ    = 4;
   localparam int DATA_W   = 8;
   localparam int CLK_DIV  = 4;
   localparam int CS_SETUP = 2;
   localparam int CS_HOLD  = 2;
   localparam int CS_GAP   = 2;

   logic clk = 1'b0;
   logic rst;
   logic loop_mode;
   logic [7:0] slv_sr;
   logic slv_bit;
   int checks = 0;
   int failures = 0;

   int n_low, rises, first_rise, last_rise, dones, hi;
   logic [7:0] bits, rx_at_done;
   logic [3:0] done_mask;

   spi_chain_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

   spi_chain_arbiter #(
      .N_REQ(N_REQ), .DATA_W(DATA_W), .CLK_DIV(CLK_DIV),
      .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   assign bus.miso = loop_mode ? bus.mosi : slv_bit;

   // SPI slave that presents 8'h5C MSB-first, changing on sclk fall.
   always @(negedge bus.cs) begin
      slv_sr  = 8'h5C;
      slv_bit = slv_sr[7];
   end
   always @(negedge bus.sclk) begin
      slv_sr  = {slv_sr[6:0], 1'b0};
      slv_bit = slv_sr[7];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cs_low(input string tag, output int hi_cnt);
      hi_cnt = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (bus.cs === 1'b0) break;
         hi_cnt++;
      end
      chk(tag, bus.cs, 0);
   endtask

   task automatic wait_idle(input string tag);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.busy === 1'b0) break;
      end
      chk(tag, bus.busy, 0);
   endtask

   // Called on the first cs-low negedge; returns on the negedge where cs is high again.
   task automatic run_frame(input int mod_at, input logic [3:0] mod_req, input logic [31:0] mod_tx);
      logic prev;
      n_low = 1; rises = 0; dones = 0; done_mask = '0; bits = '0; rx_at_done = '0;
      first_rise = -1; last_rise = -1;
      prev = bus.sclk;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (k == mod_at) begin
            bus.req     = mod_req;
            bus.tx_data = mod_tx;
         end
         if (bus.sclk && !prev) begin
            rises++;
            bits = {bits[6:0], bus.mosi};
            if (rises == 1) first_rise = k;
            last_rise = k;
         end
         prev = bus.sclk;
         if (bus.done != '0) begin
            dones++;
            done_mask = done_mask | bus.done;
            rx_at_done = bus.rx_data;
         end
         if (bus.cs) break;
         n_low++;
      end
   endtask

   initial begin
      int exp_ord[5];
      logic [7:0] exp_rx[5];
      logic [3:0] exp_gnt;
      int dcnt, lcnt;
      exp_ord = '{0, 1, 2, 3, 0};
      exp_rx  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

      loop_mode = 1'b1;
      slv_sr = 8'h00;
      slv_bit = 1'b0;
      rst = 1'b0;
      bus.req = '0;
      bus.tx_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_sclk", bus.sclk, 0);
      chk("rst_mosi", bus.mosi, 0);
      chk("rst_cs", bus.cs, 1);
      chk("rst_gnt", bus.gnt, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_rx", bus.rx_data, 0);
      chk("rst_busy", bus.busy, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // T1: single requester, loopback.
      bus.req = 4'b0001;
      bus.tx_data = 32'h000000AA;
      wait_cs_low("t1_cs_fall", hi);
      chk("t1_latency", hi, 0);
      chk("t1_gnt", bus.gnt, 4'b0001);
      chk("t1_busy", bus.busy, 1);
      chk("t1_mosi_msb", bus.mosi, 1);
      bus.req = '0;
      run_frame(-1, 4'b0000, 32'h0);
      chk("t1_cs_low_len", n_low, CS_SETUP + 2 * DATA_W * CLK_DIV + CS_HOLD);
      chk("t1_rises", rises, DATA_W);
      chk("t1_mosi_bits", bits, 8'hAA);
      chk("t1_first_rise", first_rise, CS_SETUP + CLK_DIV - 1);
      chk("t1_rise_span", last_rise - first_rise, 7 * 2 * CLK_DIV);
      chk("t1_done_cnt", dones, 1);
      chk("t1_done_mask", done_mask, 4'b0001);
      chk("t1_rx_at_done", rx_at_done, 8'hAA);
      @(negedge clk);
      chk("t1_done_clear", bus.done, 0);
      chk("t1_gap_busy", bus.busy, 1);
      chk("t1_gap_cs", bus.cs, 1);
      chk("t1_gap_gnt", bus.gnt, 0);
      chk("t1_rx_held", bus.rx_data, 8'hAA);
      wait_idle("t1_idle");

      // T6: slave drives 8'h5C on miso.
      loop_mode = 1'b0;
      bus.req = 4'b0100;
      bus.tx_data = 32'h00330000;
      wait_cs_low("t6_cs_fall", hi);
      chk("t6_gnt", bus.gnt, 4'b0100);
      bus.req = '0;
      run_frame(-1, 4'b0000, 32'h0);
      chk("t6_mosi_bits", bits, 8'h33);
      chk("t6_rx", rx_at_done, 8'h5C);
      chk("t6_done_mask", done_mask, 4'b0100);
      wait_idle("t6_idle");
      loop_mode = 1'b1;

      // T5: req and tx_data change mid-SHIFT are ignored.
      bus.req = 4'b0100;
      bus.tx_data = 32'h00C30000;
      wait_cs_low("t5_cs_fall", hi);
      chk("t5_gnt", bus.gnt, 4'b0100);
      run_frame(20, 4'b0000, 32'h005A0000);
      chk("t5_mosi_bits", bits, 8'hC3);
      chk("t5_rx", rx_at_done, 8'hC3);
      chk("t5_done_cnt", dones, 1);
      chk("t5_done_mask", done_mask, 4'b0100);
      wait_idle("t5_idle");

      // T3: grant 1 moves rr_ptr to 2, so 3 wins over 1.
      bus.req = 4'b0010;
      bus.tx_data = 32'h00009600;
      wait_cs_low("t3_cs_fall_a", hi);
      chk("t3_gnt_1", bus.gnt, 4'b0010);
      bus.req = 4'b1010;
      run_frame(-1, 4'b0000, 32'h0);
      chk("t3_rx_a", rx_at_done, 8'h96);
      wait_cs_low("t3_cs_fall_b", hi);
      chk("t3_gnt_3_first", bus.gnt, 4'b1000);
      run_frame(-1, 4'b0000, 32'h0);
      wait_cs_low("t3_cs_fall_c", hi);
      chk("t3_gnt_1_next", bus.gnt, 4'b0010);
      bus.req = '0;
      run_frame(-1, 4'b0000, 32'h0);
      wait_idle("t3_idle");

      // T2: all requesting from reset.
      rst = 1'b0;
      bus.req = 4'b1111;
      bus.tx_data = 32'h44332211;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      wait_cs_low("t2_cs_fall_0", hi);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin
            wait_cs_low("t2_cs_fall", hi);
            chk("t2_cs_high_gap", hi + 1, CS_GAP + 1);
         end
         exp_gnt = 4'b0001 << exp_ord[i];
         chk("t2_gnt_order", bus.gnt, exp_gnt);
         if (i == 4) bus.req = '0;
         run_frame(-1, 4'b0000, 32'h0);
         chk("t2_rx", rx_at_done, exp_rx[i]);
      end
      wait_idle("t2_idle");

      // T4: reset after the third sclk rise.
      bus.req = 4'b0100;
      bus.tx_data = 32'h00FF0000;
      wait_cs_low("t4_cs_fall", hi);
      chk("t4_gnt", bus.gnt, 4'b0100);
      rises = 0;
      begin
         logic prev;
         prev = bus.sclk;
         for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.sclk && !prev) rises++;
            prev = bus.sclk;
            if (rises == 3) break;
         end
      end
      chk("t4_rises_seen", rises, 3);
      rst = 1'b0;
      bus.req = '0;
      #1;
      chk("t4_cs", bus.cs, 1);
      chk("t4_sclk", bus.sclk, 0);
      chk("t4_mosi", bus.mosi, 0);
      chk("t4_gnt", bus.gnt, 0);
      chk("t4_busy", bus.busy, 0);
      chk("t4_rx_cleared", bus.rx_data, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      dcnt = 0;
      lcnt = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (bus.done != '0) dcnt++;
         if (bus.cs !== 1'b1) lcnt++;
      end
      chk("t4_no_done", dcnt, 0);
      chk("t4_stays_idle_cs", lcnt, 0);
      chk("t4_idle_busy", bus.busy, 0);
      chk("t4_idle_gnt", bus.gnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
